// File: rtl/mem_pkg.sv
// Shared data-memory definitions: legal byte-enable patterns and the DM word-address width.
package mem_pkg;

  localparam int DM_AW = 10;

  localparam logic [3:0] BE_W  = 4'hF;
  localparam logic [3:0] BE_H0 = 4'h3;
  localparam logic [3:0] BE_H1 = 4'hC;
  localparam logic [3:0] BE_B0 = 4'h1;
  localparam logic [3:0] BE_B1 = 4'h2;
  localparam logic [3:0] BE_B2 = 4'h4;
  localparam logic [3:0] BE_B3 = 4'h8;

  function automatic logic be_legal(input logic [3:0] be);
    logic ok;
    case (be)
      BE_W, BE_H0, BE_H1, BE_B0, BE_B1, BE_B2, BE_B3: ok = 1'b1;
      default:                                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store-buffer bus bundle: store request, load forwarding, flush control and DM write port.
// master = pipeline/memory side, slave = store_buffer.
interface store_buffer_if #(parameter int AW = mem_pkg::DM_AW) ();
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_A;
  logic [3:0]    st_be;
  logic [31:0]   st_D;
  logic          drain_hold;
  logic          flush_req;
  logic          flush_done;
  logic [AW-1:0] ld_A;
  logic [31:0]   dm_Dout;
  logic [31:0]   ld_data;
  logic          empty;
  logic [AW-1:0] dm_A;
  logic [3:0]    dm_be;
  logic [31:0]   dm_D;
  logic          dm_memWrite;

  modport master (
    output st_valid, st_A, st_be, st_D, drain_hold, flush_req, ld_A, dm_Dout,
    input  st_ready, flush_done, ld_data, empty, dm_A, dm_be, dm_D, dm_memWrite
  );

  modport slave (
    input  st_valid, st_A, st_be, st_D, drain_hold, flush_req, ld_A, dm_Dout,
    output st_ready, flush_done, ld_data, empty, dm_A, dm_be, dm_D, dm_memWrite
  );
endinterface

// File: rtl/sb_fwd_merge.sv
// Per-lane store-to-load forwarding: each byte lane takes the youngest valid
// matching entry that writes that lane, else the DM read data.
module sb_fwd_merge #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic [AW-1:0]              a_i     [DEPTH],
  input  logic [3:0]                 be_i    [DEPTH],
  input  logic [31:0]                d_i     [DEPTH],
  input  logic [DEPTH-1:0]           valid_i,
  input  logic [$clog2(DEPTH)-1:0]   head_i,
  input  logic [AW-1:0]              ld_a_i,
  input  logic [31:0]                dm_dout_i,
  output logic [31:0]                ld_data_o
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx_s;
  logic [31:0]   acc_s;

  // Walk oldest to youngest so a later match overrides an earlier one per lane.
  always_comb begin
    acc_s = dm_dout_i;
    idx_s = head_i;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = head_i + PW'(i);
      for (int k = 0; k < 4; k++) begin
        acc_s[8*k +: 8] = (valid_i[idx_s] && (a_i[idx_s] == ld_a_i) && be_i[idx_s][k])
                          ? d_i[idx_s][8*k +: 8] : acc_s[8*k +: 8];
      end
    end
  end

  assign ld_data_o = acc_s;

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order FIFO draining one entry per cycle into DM,
// with load forwarding. Define STORE_BUFFER_COALESCE_EN to merge pushes into the youngest entry.
module store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = DM_AW
) (
  input  logic         clk,
  input  logic         rst,
  store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [AW-1:0]    a_q  [DEPTH];
  logic [3:0]       be_q [DEPTH];
  logic [31:0]      d_q  [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, young_s, off_s;
  logic [PW:0]      count_q, count_d;
  logic [DEPTH-1:0] valid_s;
  logic             full_s, empty_s, drain_s, merge_s, ready_s, push_s, alloc_s;

  // Occupancy, drain and push/merge decisions.
  always_comb begin
    full_s  = (count_q == CNT_FULL);
    empty_s = (count_q == '0);
    drain_s = !empty_s && !sb.drain_hold;
    young_s = tail_q - PTR_ONE;
`ifdef STORE_BUFFER_COALESCE_EN
    merge_s = !empty_s && (a_q[young_s] == sb.st_A) &&
              !(drain_s && (young_s == head_q)) &&
              be_legal(be_q[young_s] | sb.st_be);
`else
    merge_s = 1'b0;
`endif
    ready_s = !sb.flush_req && (!full_s || merge_s);
    push_s  = sb.st_valid && ready_s;
    alloc_s = push_s && !merge_s;
    count_d = count_q + {{PW{1'b0}}, alloc_s} - {{PW{1'b0}}, drain_s};
    head_d  = drain_s ? (head_q + PTR_ONE) : head_q;
    tail_d  = alloc_s ? (tail_q + PTR_ONE) : tail_q;
  end

  // Slot valid mask: a slot is live if its distance from head is below count.
  always_comb begin
    valid_s = '0;
    off_s   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off_s      = PW'(i) - head_q;
      valid_s[i] = ({1'b0, off_s} < count_q);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage: allocate at tail, or overlay new bytes onto the youngest entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i]  <= '0;
        be_q[i] <= '0;
        d_q[i]  <= '0;
      end
    end else if (alloc_s) begin
      a_q[tail_q]  <= sb.st_A;
      be_q[tail_q] <= sb.st_be;
      d_q[tail_q]  <= sb.st_D;
    end else if (push_s && merge_s) begin
      be_q[young_s] <= be_q[young_s] | sb.st_be;
      for (int k = 0; k < 4; k++) begin
        if (sb.st_be[k]) begin
          d_q[young_s][8*k +: 8] <= sb.st_D[8*k +: 8];
        end
      end
    end
  end

  sb_fwd_merge #(.DEPTH(DEPTH), .AW(AW)) u_fwd (
    .a_i       (a_q),
    .be_i      (be_q),
    .d_i       (d_q),
    .valid_i   (valid_s),
    .head_i    (head_q),
    .ld_a_i    (sb.ld_A),
    .dm_dout_i (sb.dm_Dout),
    .ld_data_o (sb.ld_data)
  );

  assign sb.st_ready   = ready_s;
  assign sb.empty      = empty_s;
  assign sb.flush_done = sb.flush_req && empty_s;
  assign sb.dm_memWrite = drain_s;
  assign sb.dm_A       = a_q[head_q];
  assign sb.dm_be      = be_q[head_q];
  assign sb.dm_D       = d_q[head_q];

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model compared every cycle,
// plus directed vectors with hand-computed values. Honours STORE_BUFFER_COALESCE_EN.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 10;

  typedef struct {
    logic [AW-1:0] a;
    logic [3:0]    be;
    logic [31:0]   d;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  ent_t mq[$];
  int   n_vec = 0;
  int   n_err = 0;

  store_buffer_if #(.AW(AW)) sbi ();
  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .sb(sbi));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit legal(input logic [3:0] be);
    return be inside {4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
  endfunction

  function automatic bit m_drain();
    return (mq.size() != 0) && !sbi.drain_hold;
  endfunction

  function automatic bit m_merge();
`ifdef STORE_BUFFER_COALESCE_EN
    if (mq.size() == 0) return 1'b0;
    if (mq[$].a != sbi.st_A) return 1'b0;
    if (mq.size() == 1 && m_drain()) return 1'b0;
    return legal(mq[$].be | sbi.st_be);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_ready();
    return !sbi.flush_req && ((mq.size() < DEPTH) || m_merge());
  endfunction

  function automatic logic [31:0] m_load();
    logic [31:0] r;
    r = sbi.dm_Dout;
    for (int k = 0; k < 4; k++) begin
      for (int j = mq.size() - 1; j >= 0; j--) begin
        if (mq[j].a == sbi.ld_A && mq[j].be[k]) begin
          r[8*k +: 8] = mq[j].d[8*k +: 8];
          break;
        end
      end
    end
    return r;
  endfunction

  task automatic model_check();
    chk("st_ready",    32'(sbi.st_ready),    32'(m_ready()));
    chk("empty",       32'(sbi.empty),       32'(mq.size() == 0));
    chk("flush_done",  32'(sbi.flush_done),  32'(sbi.flush_req && (mq.size() == 0)));
    chk("dm_memWrite", 32'(sbi.dm_memWrite), 32'(m_drain()));
    chk("ld_data",     sbi.ld_data,          m_load());
    if (m_drain()) begin
      chk("dm_A",  32'(sbi.dm_A),  32'(mq[0].a));
      chk("dm_be", 32'(sbi.dm_be), 32'(mq[0].be));
      chk("dm_D",  sbi.dm_D,       mq[0].d);
    end
  endtask

  task automatic model_update();
    bit   push, drain, merge;
    ent_t e;
    if (rst) begin
      mq.delete();
      return;
    end
    drain = m_drain();
    merge = m_merge();
    push  = sbi.st_valid && m_ready();
    if (push && merge) begin
      e = mq[$];
      e.be = e.be | sbi.st_be;
      for (int k = 0; k < 4; k++)
        if (sbi.st_be[k]) e.d[8*k +: 8] = sbi.st_D[8*k +: 8];
      mq[$] = e;
    end else if (push) begin
      e.a = sbi.st_A; e.be = sbi.st_be; e.d = sbi.st_D;
      mq.push_back(e);
    end
    if (drain) void'(mq.pop_front());
  endtask

  task automatic tick();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic put(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    sbi.st_valid = 1'b1; sbi.st_A = a; sbi.st_be = be; sbi.st_D = d;
    tick();
    sbi.st_valid = 1'b0;
  endtask

  task automatic drain_all();
    sbi.drain_hold = 1'b0;
    sbi.st_valid   = 1'b0;
    for (int i = 0; i < 4*DEPTH; i++) begin
      if (mq.size() == 0) break;
      tick();
    end
    #1 chk("drained_empty", 32'(sbi.empty), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    sbi.st_valid = 1'b0; sbi.st_A = '0; sbi.st_be = 4'h0; sbi.st_D = 32'h0;
    sbi.drain_hold = 1'b0; sbi.flush_req = 1'b0;
    sbi.ld_A = 10'h3FF; sbi.dm_Dout = 32'hCAFE0000;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(sbi.st_ready),    32'd1);
    chk("rst_empty", 32'(sbi.empty),       32'd1);
    chk("rst_we",    32'(sbi.dm_memWrite), 32'd0);
    chk("rst_fdone", 32'(sbi.flush_done),  32'd0);
    rst = 1'b0;
    mq.delete();
    @(negedge clk);

    // single store, forwarding, then drain
    sbi.drain_hold = 1'b1;
    put(10'd5, 4'hF, 32'h11223344);
    sbi.ld_A = 10'd5; sbi.dm_Dout = 32'h0;
    #1 chk("t1_fwd", sbi.ld_data, 32'h11223344);
    tick();
    sbi.drain_hold = 1'b0;
    #1;
    chk("t1_we",  32'(sbi.dm_memWrite), 32'd1);
    chk("t1_dmA", 32'(sbi.dm_A),        32'd5);
    tick();
    #1 chk("t1_empty", 32'(sbi.empty), 32'd1);

    // forwarding priority; a store being pushed does not yet forward
    sbi.drain_hold = 1'b1;
    sbi.ld_A = 10'd7; sbi.dm_Dout = 32'hFFFFFFFF;
    put(10'd7, 4'hF, 32'hAAAAAAAA);
    put(10'd7, 4'h1, 32'h00000055);
    sbi.st_valid = 1'b1; sbi.st_A = 10'd7; sbi.st_be = 4'hC; sbi.st_D = 32'h12340000;
    #1 chk("t2_nofwd_push", sbi.ld_data, 32'hAAAAAA55);
    tick();
    sbi.st_valid = 1'b0;
    #1 chk("t2_fwd_prio", sbi.ld_data, 32'h1234AA55);
    drain_all();
    sbi.ld_A = 10'h3FF;

    // full, no fall-through, wrap
    sbi.drain_hold = 1'b1;
    for (int i = 0; i < 4; i++) put(AW'(16 + i), 4'hF, 32'h10000000 + 32'(i));
    sbi.st_valid = 1'b1; sbi.st_A = 10'h014; sbi.st_be = 4'hF; sbi.st_D = 32'h14141414;
    #1 chk("t3_full_ready", 32'(sbi.st_ready), 32'd0);
    tick();
    sbi.drain_hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sbi.st_valid = (i < 2);
      #1;
      chk("t3_order_we", 32'(sbi.dm_memWrite), 32'd1);
      chk("t3_order_A",  32'(sbi.dm_A),        32'h10 + 32'(i));
      if (i == 0) chk("t3_full_drain_ready", 32'(sbi.st_ready), 32'd0);
      if (i == 1) chk("t3_after_drain_ready", 32'(sbi.st_ready), 32'd1);
      tick();
    end
    #1 chk("t3_empty", 32'(sbi.empty), 32'd1);

    // simultaneous push and drain at count 2
    sbi.drain_hold = 1'b1;
    put(10'h020, 4'hF, 32'h20202020);
    put(10'h021, 4'hF, 32'h21212121);
    sbi.drain_hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sbi.st_valid = 1'b1; sbi.st_A = AW'(34 + i); sbi.st_be = 4'hF; sbi.st_D = 32'(i);
      #1;
      chk("t4_dmA",   32'(sbi.dm_A),     32'h20 + 32'(i));
      chk("t4_ready", 32'(sbi.st_ready), 32'd1);
      chk("t4_empty", 32'(sbi.empty),    32'd0);
      tick();
    end
    sbi.st_valid = 1'b0;
    drain_all();

    // flush
    sbi.drain_hold = 1'b1;
    for (int i = 0; i < 3; i++) put(AW'(48 + i), 4'hF, 32'h30303030 + 32'(i));
    sbi.flush_req = 1'b1; sbi.drain_hold = 1'b0;
    sbi.st_valid = 1'b1; sbi.st_A = 10'h033; sbi.st_be = 4'hF; sbi.st_D = 32'h33333333;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_ready", 32'(sbi.st_ready),   32'd0);
      chk("t5_fdone", 32'(sbi.flush_done), 32'd0);
      chk("t5_dmA",   32'(sbi.dm_A),       32'h30 + 32'(i));
      tick();
    end
    #1;
    chk("t5_fdone_rise", 32'(sbi.flush_done), 32'd1);
    chk("t5_empty",      32'(sbi.empty),      32'd1);
    tick();
    sbi.flush_req = 1'b0; sbi.st_valid = 1'b0;

    // reset mid-drain
    sbi.drain_hold = 1'b1;
    put(10'h040, 4'hF, 32'h40404040);
    put(10'h041, 4'hF, 32'h41414141);
    sbi.drain_hold = 1'b0;
    #1 chk("t6_we_before", 32'(sbi.dm_memWrite), 32'd1);
    rst = 1'b1;
    mq.delete();
    #1;
    chk("t6_we_rst",    32'(sbi.dm_memWrite), 32'd0);
    chk("t6_empty_rst", 32'(sbi.empty),       32'd1);
    tick();
    rst = 1'b0;
    tick();

    // illegal byte enable passes through unchanged
    sbi.drain_hold = 1'b1;
    put(10'h050, 4'h5, 32'h00FF00FF);
    sbi.drain_hold = 1'b0;
    #1;
    chk("t7_illegal_be", 32'(sbi.dm_be), 32'h5);
    chk("t7_illegal_D",  sbi.dm_D,       32'h00FF00FF);
    tick();

    // coalescing candidates (merged only when the feature is built in)
    sbi.drain_hold = 1'b1;
    put(10'd9, 4'h3, 32'h0000BEEF);
    put(10'd9, 4'hC, 32'hDEAD0000);
    sbi.drain_hold = 1'b0;
`ifdef STORE_BUFFER_COALESCE_EN
    #1; chk("t8_be", 32'(sbi.dm_be), 32'hF); chk("t8_D", sbi.dm_D, 32'hDEADBEEF);
    tick(); #1 chk("t8_single", 32'(sbi.empty), 32'd1);
`else
    #1; chk("t8_be", 32'(sbi.dm_be), 32'h3); chk("t8_D", sbi.dm_D, 32'h0000BEEF);
    tick(); #1 chk("t8_single", 32'(sbi.empty), 32'd0);
`endif
    drain_all();

    sbi.drain_hold = 1'b1;
    put(10'h00A, 4'h1, 32'h000000A1);
    put(10'h00A, 4'h2, 32'h0000A200);
    sbi.drain_hold = 1'b0;
`ifdef STORE_BUFFER_COALESCE_EN
    #1; chk("t9_be", 32'(sbi.dm_be), 32'h3); chk("t9_D", sbi.dm_D, 32'h0000A2A1);
    tick(); #1 chk("t9_single", 32'(sbi.empty), 32'd1);
`else
    #1; chk("t9_be", 32'(sbi.dm_be), 32'h1); chk("t9_D", sbi.dm_D, 32'h000000A1);
    tick(); #1 chk("t9_single", 32'(sbi.empty), 32'd0);
`endif
    drain_all();

    sbi.drain_hold = 1'b1;
    put(10'h00B, 4'h1, 32'h000000B1);
    put(10'h00B, 4'h4, 32'h00B40000);
    sbi.drain_hold = 1'b0;
    #1 chk("t10_be0", 32'(sbi.dm_be), 32'h1);
    tick();
    #1;
    chk("t10_two_entries", 32'(sbi.empty), 32'd0);
    chk("t10_be1",         32'(sbi.dm_be), 32'h4);
    drain_all();

    // merge into youngest while full
    sbi.drain_hold = 1'b1;
    for (int i = 0; i < 4; i++) put(AW'(96 + i), 4'h1, 32'h00000060 + 32'(i));
    sbi.st_valid = 1'b1; sbi.st_A = 10'h063; sbi.st_be = 4'h2; sbi.st_D = 32'h00006300;
`ifdef STORE_BUFFER_COALESCE_EN
    #1 chk("t11_full_merge_ready", 32'(sbi.st_ready), 32'd1);
`else
    #1 chk("t11_full_merge_ready", 32'(sbi.st_ready), 32'd0);
`endif
    tick();
    sbi.st_valid = 1'b0;
    sbi.ld_A = 10'h063; sbi.dm_Dout = 32'h0;
    tick();
    drain_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
